// File: rtl/lcd_pkg.sv
// lcd_pkg: timing defaults, HD44780 command bytes, FSM encodings and small helpers
// shared by lcd_char_writer and lcd_nibble_tx.
package lcd_pkg;

  // Timer sizing
  localparam int unsigned TMR_W   = 20;
  localparam int unsigned TMR_MAX = (1 << TMR_W) - 1;

  // Default bus timing in clk cycles at 50 MHz
  localparam int unsigned T_POWERUP_DEF = 750000;
  localparam int unsigned T_INIT1_DEF   = 205000;
  localparam int unsigned T_INIT2_DEF   = 5000;
  localparam int unsigned T_SETUP_DEF   = 2;
  localparam int unsigned T_E_HIGH_DEF  = 12;
  localparam int unsigned T_NIB_GAP_DEF = 50;
  localparam int unsigned T_CMD_DEF     = 2000;
  localparam int unsigned T_CLEAR_DEF   = 82000;

  // Controller command bytes
  localparam logic [7:0] LCD_FUNC_SET  = 8'h28;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_INIT_START,
    ST_INIT_DONE,
    ST_INIT_WAIT,
    ST_HI_START,
    ST_HI_DONE,
    ST_GAP,
    ST_LO_START,
    ST_LO_DONE,
    ST_BYTE_WAIT,
    ST_IDLE
  } lcd_state_e;

  // Which byte the byte engine is currently sending
  typedef enum logic [1:0] {
    PH_CFG,
    PH_ADDR,
    PH_DATA
  } lcd_phase_e;

  // Nibble strobe generator states
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HIGH,
    TX_HOLD
  } tx_state_e;

  // Latched client write
  typedef struct packed {
    logic [4:0] loc;
    logic [7:0] data;
  } lcd_wr_t;

  // Configuration byte sequence after the nibble-mode handshake
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_byte = LCD_FUNC_SET;
      2'd1:    cfg_byte = LCD_ENTRY;
      2'd2:    cfg_byte = LCD_DISP_ON;
      default: cfg_byte = LCD_CLEAR;
    endcase
  endfunction

  // Init handshake nibbles: 3, 3, 3 then 2 to enter 4-bit mode
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    init_nibble = (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  // DDRAM address command: row 1 starts at 0x40
  function automatic logic [7:0] ddram_cmd(input logic [4:0] loc);
    ddram_cmd = LCD_SET_DDRAM | {1'b0, loc[4], 2'b00, loc[3:0]};
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: puts one nibble on the LCD bus with setup, E-high and hold phases,
// then pulses done_o. SF_D/RS keep their value until the next start.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP  = T_SETUP_DEF,
  parameter int unsigned T_E_HIGH = T_E_HIGH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [3:0] nibble_i,
  output logic [3:0] sf_d_o,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic       done_o
);

  localparam int unsigned CNT_MAX = (T_SETUP > T_E_HIGH) ? T_SETUP : T_E_HIGH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         nib_q, nib_d;
  logic               rs_q, rs_d;
  logic               e_q, e_d;
  logic               done_q, done_d;

  // Strobe state and bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      nib_q   <= 4'h0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  // Phase sequencing: setup (E low) -> E high -> one hold cycle -> done
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    nib_d   = nib_q;
    rs_d    = rs_q;
    done_d  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          nib_d   = nibble_i;
          rs_d    = rs_i;
          cnt_d   = CNT_W'(T_SETUP - 1);
          state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(T_E_HIGH - 1);
          state_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        if (cnt_q == '0) state_d = TX_HOLD;
      end
      TX_HOLD: begin
        done_d  = 1'b1;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
    e_d = (state_d == TX_HIGH);
  end

  assign sf_d_o   = nib_q;
  assign lcd_rs_o = rs_q;
  assign lcd_e_o  = e_q;
  assign done_o   = done_q;

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: character-write slave driving a 2x16 HD44780 LCD over its 4-bit bus.
// Runs power-up init, then turns each accepted (location, data) write into a DDRAM
// address command followed by a data byte.
// Optional build macro LCD_ADDR_SKIP_EN: track the LCD's auto-incremented address and
// skip the address command when the next write lands on it.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = T_POWERUP_DEF,
  parameter int unsigned T_INIT1   = T_INIT1_DEF,
  parameter int unsigned T_INIT2   = T_INIT2_DEF,
  parameter int unsigned T_SETUP   = T_SETUP_DEF,
  parameter int unsigned T_E_HIGH  = T_E_HIGH_DEF,
  parameter int unsigned T_NIB_GAP = T_NIB_GAP_DEF,
  parameter int unsigned T_CMD     = T_CMD_DEF,
  parameter int unsigned T_CLEAR   = T_CLEAR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       writeEnable,
  input  logic [4:0] location,
  input  logic [7:0] data,
  output logic       busy,
  output logic       initDone,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  // One nibble slot: start cycle + setup + E high + hold + done handshake
  localparam int unsigned NIB_CYCLES   = T_SETUP + T_E_HIGH + 3;
  localparam int unsigned BYTE_CYCLES  = 2 * NIB_CYCLES + T_NIB_GAP + T_CMD;
  // Accept edge to busy-low edge for a write that sends its address command
  localparam int unsigned WRITE_CYCLES = 2 * BYTE_CYCLES;

  // Every wait, and the write latency, must fit the down-counter
  if (T_POWERUP > TMR_MAX || T_INIT1 > TMR_MAX || T_INIT2 > TMR_MAX ||
      T_CLEAR > TMR_MAX || WRITE_CYCLES > TMR_MAX) begin : g_timer_range
    $error("lcd_char_writer: timing parameter exceeds timer range");
  end

  lcd_state_e        state_q, state_d;
  lcd_phase_e        phase_q, phase_d;
  logic [1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  lcd_wr_t           wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;

  logic [7:0]        cur_byte_c;
  logic              tmr_exp_c;
  logic              tx_start_c;
  logic              tx_rs_c;
  logic [3:0]        tx_nib_c;
  logic              tx_done;

`ifdef LCD_ADDR_SKIP_EN
  logic [4:0]        trk_loc_q, trk_loc_d;
  logic              trk_vld_q, trk_vld_d;
`endif

  // Sequencer state, timer, latched write and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWR_WAIT;
      phase_q     <= PH_CFG;
      idx_q       <= 2'd0;
      timer_q     <= '0;
      wr_q        <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
`ifdef LCD_ADDR_SKIP_EN
      trk_loc_q   <= 5'd0;
      trk_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
`ifdef LCD_ADDR_SKIP_EN
      trk_loc_q   <= trk_loc_d;
      trk_vld_q   <= trk_vld_d;
`endif
    end
  end

  // Byte currently being sent by the byte engine
  always_comb begin
    cur_byte_c = wr_q.data;
    case (phase_q)
      PH_CFG:  cur_byte_c = cfg_byte(idx_q);
      PH_ADDR: cur_byte_c = ddram_cmd(wr_q.loc);
      default: cur_byte_c = wr_q.data;
    endcase
  end

  assign tmr_exp_c = (timer_q <= TMR_W'(1));

  // Next-state: power-up wait, init nibbles, config bytes, then client writes
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    timer_d     = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
    wr_d        = wr_q;
    tx_start_c  = 1'b0;
    tx_rs_c     = (phase_q == PH_DATA);
    tx_nib_c    = cur_byte_c[7:4];
`ifdef LCD_ADDR_SKIP_EN
    trk_loc_d   = trk_loc_q;
    trk_vld_d   = trk_vld_q;
`endif
    unique case (state_q)
      ST_PWR_WAIT: begin
        // Timer is cleared by reset; the first cycle arms the power-up wait
        if (timer_q == '0) begin
          timer_d = TMR_W'(T_POWERUP);
        end else if (timer_q == TMR_W'(1)) begin
          idx_d   = 2'd0;
          state_d = ST_INIT_START;
        end
      end
      ST_INIT_START: begin
        tx_start_c = 1'b1;
        tx_rs_c    = 1'b0;
        tx_nib_c   = init_nibble(idx_q);
        state_d    = ST_INIT_DONE;
      end
      ST_INIT_DONE: begin
        if (tx_done) begin
          case (idx_q)
            2'd0:    timer_d = TMR_W'(T_INIT1);
            2'd1:    timer_d = TMR_W'(T_INIT2);
            default: timer_d = TMR_W'(T_CMD);
          endcase
          state_d = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT: begin
        if (tmr_exp_c) begin
          if (idx_q == 2'd3) begin
            phase_d = PH_CFG;
            idx_d   = 2'd0;
            state_d = ST_HI_START;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT_START;
          end
        end
      end
      ST_HI_START: begin
        tx_start_c = 1'b1;
        state_d    = ST_HI_DONE;
      end
      ST_HI_DONE: begin
        if (tx_done) begin
          timer_d = TMR_W'(T_NIB_GAP);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_exp_c) state_d = ST_LO_START;
      end
      ST_LO_START: begin
        tx_start_c = 1'b1;
        tx_nib_c   = cur_byte_c[3:0];
        state_d    = ST_LO_DONE;
      end
      ST_LO_DONE: begin
        if (tx_done) begin
          timer_d = (phase_q == PH_CFG && idx_q == 2'd3) ? TMR_W'(T_CLEAR) : TMR_W'(T_CMD);
          state_d = ST_BYTE_WAIT;
        end
      end
      ST_BYTE_WAIT: begin
        if (tmr_exp_c) begin
          case (phase_q)
            PH_CFG: begin
              if (idx_q == 2'd3) begin
                state_d = ST_IDLE;
              end else begin
                idx_d   = idx_q + 2'd1;
                state_d = ST_HI_START;
              end
            end
            PH_ADDR: begin
              phase_d = PH_DATA;
              state_d = ST_HI_START;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_IDLE: begin
        if (writeEnable) begin
          wr_d    = '{loc: location, data: data};
          phase_d = PH_ADDR;
          state_d = ST_HI_START;
`ifdef LCD_ADDR_SKIP_EN
          // LCD address auto-increments after the data byte; col 15 leaves the row
          if (trk_vld_q && trk_loc_q == location) phase_d = PH_DATA;
          trk_loc_d = location + 5'd1;
          trk_vld_d = (location[3:0] != 4'hF);
`endif
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
    busy_d      = (state_d != ST_IDLE);
    init_done_d = init_done_q | (state_d == ST_IDLE);
  end

  // Nibble strobe generator owning SF_D / LCD_RS / LCD_E
  lcd_nibble_tx #(
    .T_SETUP  (T_SETUP),
    .T_E_HIGH (T_E_HIGH)
  ) u_nibble_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (tx_start_c),
    .rs_i     (tx_rs_c),
    .nibble_i (tx_nib_c),
    .sf_d_o   (SF_D),
    .lcd_rs_o (LCD_RS),
    .lcd_e_o  (LCD_E),
    .done_o   (tx_done)
  );

  assign busy     = busy_q;
  assign initDone = init_done_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: random and directed character writes against a nibble-level
// reference model of the LCD bus, with an E-strobe monitor on every transfer.
module tb_lcd_char_writer;

  localparam int T_POWERUP = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 30;
  localparam int T_SETUP   = 2;
  localparam int T_E_HIGH  = 12;
  localparam int T_NIB_GAP = 50;

  // Nibble on the bus is setup + E high + hold, plus a start cycle and a done handshake
  localparam int BYTE_CYC  = 2 * (T_SETUP + T_E_HIGH + 1 + 2) + T_NIB_GAP + T_CMD;

`ifdef LCD_ADDR_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       we = 1'b0;
  logic [4:0] loc = 5'd0;
  logic [7:0] dat = 8'd0;
  logic       busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] sf_d;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  logic [4:0] got_q[$];
  logic [4:0] exp_q[$];

  // Model of the LCD's auto-increment address
  bit mdl_vld = 1'b0;
  int mdl_next = 0;

  lcd_char_writer #(
    .T_POWERUP (T_POWERUP), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2),
    .T_SETUP (T_SETUP), .T_E_HIGH (T_E_HIGH), .T_NIB_GAP (T_NIB_GAP),
    .T_CMD (T_CMD), .T_CLEAR (T_CLEAR)
  ) dut (
    .clk (clk), .rst_n (rst_n), .writeEnable (we), .location (loc), .data (dat),
    .busy (busy), .initDone (init_done), .SF_D (sf_d), .LCD_E (lcd_e),
    .LCD_RS (lcd_rs), .LCD_RW (lcd_rw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // E strobe monitor: capture {RS,nibble} at each rising E, check width/stability/RW
  logic       e_prev = 1'b0;
  logic       e_bad = 1'b0;
  logic [3:0] e_nib = 4'h0;
  logic       e_rs = 1'b0;
  int         e_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev = 1'b0;
      e_bad  = 1'b0;
      e_cnt  = 0;
    end else begin
      if (lcd_e) begin
        if (!e_prev) begin
          got_q.push_back({lcd_rs, sf_d});
          e_nib = sf_d;
          e_rs  = lcd_rs;
          e_cnt = 0;
        end else if (sf_d != e_nib || lcd_rs != e_rs) begin
          e_bad = 1'b1;
        end
        e_cnt++;
      end else if (e_prev) begin
        check_val("e_high_width", e_cnt, T_E_HIGH);
        check_val("e_bus_stable", int'(e_bad), 0);
        check_val("lcd_rw", int'(lcd_rw), 0);
        e_bad = 1'b0;
        last_fall_cyc = cyc;
      end
      e_prev = lcd_e;
    end
  end

  function automatic void push_byte(input bit rs, input int b);
    exp_q.push_back({rs, 4'(b / 16)});
    exp_q.push_back({rs, 4'(b % 16)});
  endfunction

  // Expected bus traffic of one write; returns expected accept-to-idle cycles
  function automatic int model_write(input int l, input int d);
    bit skip;
    int addr;
    skip     = SKIP_EN && mdl_vld && (mdl_next == l);
    mdl_vld  = (l % 16) != 15;
    mdl_next = l + 1;
    addr     = 'h80 + ((l >= 16) ? 'h40 : 0) + (l % 16);
    if (!skip) push_byte(1'b0, addr);
    push_byte(1'b1, d);
    return skip ? BYTE_CYC : 2 * BYTE_CYC;
  endfunction

  task automatic compare_nibbles(input string tag);
    check_val({tag, "_nibble_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("%s_nibble[%0d]", tag, i), int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // Called right after reset release: expect the full init sequence
  task automatic run_init(input string tag);
    int seq[8] = '{3, 3, 3, 2, 'h28, 'h06, 'h0C, 'h01};
    int n, first_e;
    bit early;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 4'(seq[i])});
    for (int i = 4; i < 8; i++) push_byte(1'b0, seq[i]);
    n = 0; first_e = 0; early = 1'b0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
      if (lcd_e && first_e == 0) first_e = n;
      if (busy && init_done) early = 1'b1;
    end
    check_val({tag, "_busy_released"}, int'(busy), 0);
    check_val({tag, "_init_done"}, int'(init_done), 1);
    check_val({tag, "_no_early_done"}, int'(early), 0);
    check_val({tag, "_powerup_wait"}, int'(first_e > T_POWERUP), 1);
    check_val({tag, "_clear_wait"}, int'((cyc - last_fall_cyc) >= T_CLEAR), 1);
    compare_nibbles(tag);
  endtask

  task automatic do_write(input int l, input int d, input bit poke);
    int exp_lat, n;
    exp_lat = model_write(l, d);
    @(negedge clk);
    we = 1'b1; loc = 5'(l); dat = 8'(d);
    @(posedge clk); #1;
    we = 1'b0;
    check_val("busy_after_accept", int'(busy), 1);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 20) begin we = 1'b1; loc = 5'd3; dat = 8'h5A; end
      if (poke && n == 22) we = 1'b0;
    end
    check_val($sformatf("write_latency_loc%0d", l), n, exp_lat);
    compare_nibbles($sformatf("wr_loc%0d", l));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, int'(busy), 1);
    check_val({tag, "_init_done"}, int'(init_done), 0);
    check_val({tag, "_lcd_e"}, int'(lcd_e), 0);
    check_val({tag, "_sf_d"}, int'(sf_d), 0);
    check_val({tag, "_lcd_rs"}, int'(lcd_rs), 0);
    check_val({tag, "_lcd_rw"}, int'(lcd_rw), 0);
  endtask

  initial begin
    #100_000_0;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l, d, prev, n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    run_init("init");

    // Directed writes, including one poked with writeEnable while busy
    do_write(5, 'h41, 1'b0);
    do_write(17, 'h7A, 1'b0);
    do_write(8, 'h33, 1'b1);
    do_write(9, 'h34, 1'b0);

    // Auto-increment boundaries
    do_write(0, 'h61, 1'b0);
    do_write(1, 'h62, 1'b0);
    do_write(15, 'h63, 1'b0);
    do_write(16, 'h64, 1'b0);

    // Random writes, half of them to the next consecutive cell
    prev = 16;
    for (int i = 0; i < 12; i++) begin
      l = ($urandom_range(0, 1) == 1) ? (prev + 1) % 32 : int'($urandom_range(0, 31));
      d = int'($urandom_range(32, 126));
      do_write(l, d, 1'b0);
      prev = l;
    end

    // Reset during the first data nibble's E-high window
    l = 20; d = 'h55;
    void'(model_write(l, d));
    void'(exp_q.pop_back());
    @(negedge clk);
    we = 1'b1; loc = 5'(l); dat = 8'(d);
    @(posedge clk); #1;
    we = 1'b0;
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("mid_data_nibble_reached", int'(lcd_e & lcd_rs), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    mdl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init("reinit");
    do_write(int'($urandom_range(0, 31)), int'($urandom_range(32, 126)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
